// File: rtl/reset_detect_mc_if.sv
// Host register bus for reset_detect_mc.
//
// Handshake: reg_wr is a single-cycle write strobe qualified by reg_addr and
// reg_wdata on the same CLK60MHZ rising edge. There is no ready signal; every
// write is accepted in the cycle it is presented. reg_rdata is combinational
// from reg_addr and the register state, so a read needs no strobe.
//
// Signals:
//   reg_wr     host -> block  write strobe
//   reg_addr   host -> block  4-bit register address
//   reg_wdata  host -> block  32-bit write data
//   reg_rdata  block -> host  32-bit read data
interface reset_detect_mc_if;
  logic        reg_wr;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (output reg_wr, output reg_addr, output reg_wdata, input reg_rdata);
  modport slave  (input reg_wr, input reg_addr, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/reset_detect_mc.sv
// reset_detect_mc: multi-channel reset-source detector.
//
// Each raw active-low reset source is synchronised, noise filtered and
// reported on rst_filt_b. While break mode (svmoduser) is active, an
// unmasked filtered reset raises a sticky flag; flag_any is the registered
// OR of the flags. Optional per-channel event counters count filtered
// falling edges.
//
// Optional feature: define RESET_DETECT_MC_CNT_EN to build the event
// counters (addresses 8..8+NCH-1). Without it those addresses read 0 and
// writes to them are ignored.
//
// Ports:
//   CLK60MHZ    system clock, all state on its rising edge
//   pocrflclr   asynchronous active-high reset
//   rst_b       raw active-low reset sources (asynchronous)
//   svmoduser   break-mode user SVMOD (asynchronous)
//   bus         host register bus (reset_detect_mc_if.slave)
//   rst_filt_b  filtered active-low resets
//   flag_any    OR of all flags, registered
//
// Register map: 0 flags (W1C), 1 mask (R/W), 2 {svmod_s, rst_filt_b} (RO),
// 8+i cnt[i] (R/W). Everything else reads 0 and ignores writes.
module reset_detect_mc #(
  parameter int NCH = 4,
  parameter int FLT_LEN = 6,
  parameter int CNT_W = 8,
  parameter logic [NCH-1:0] AUTOCLR_MASK = {NCH{1'b0}}
) (
  input  logic                CLK60MHZ,
  input  logic                pocrflclr,
  input  logic [NCH-1:0]      rst_b,
  input  logic                svmoduser,
  reset_detect_mc_if.slave    bus,
  output logic [NCH-1:0]      rst_filt_b,
  output logic                flag_any
);

  localparam logic [7:0] FLT_RELOAD = 8'(FLT_LEN - 1);

  logic [NCH-1:0] rst_s1, rst_s2, rst_prev;
  logic [7:0]     flt_cnt [NCH];
  logic           sv_s1, svmod_s, svmod_d;
  logic [NCH-1:0] flag, mask;
  logic [NCH-1:0] flag_set, flag_clr, flag_nxt;
  logic           wr_flag, wr_mask, autoclr;
  logic [31:0]    rdata;
  logic           unused_wdata;

  assign unused_wdata = ^bus.reg_wdata;

  // Two-flop synchronisers. The SVMOD synchroniser resets to its inactive
  // level (0) so leaving reset never looks like a break-mode exit.
  always_ff @(posedge CLK60MHZ or posedge pocrflclr) begin
    if (pocrflclr) begin
      rst_s1  <= '1;
      rst_s2  <= '1;
      sv_s1   <= 1'b0;
      svmod_s <= 1'b0;
      svmod_d <= 1'b0;
    end else begin
      rst_s1  <= rst_b;
      rst_s2  <= rst_s1;
      sv_s1   <= svmoduser;
      svmod_s <= sv_s1;
      svmod_d <= svmod_s;
    end
  end

  // Glitch filter: any change of the synchronised input reloads the counter;
  // the output follows on the edge where the counter steps 1 -> 0, i.e. after
  // FLT_LEN identical synchronised samples.
  always_ff @(posedge CLK60MHZ or posedge pocrflclr) begin
    if (pocrflclr) begin
      rst_prev   <= '1;
      rst_filt_b <= '1;
      for (int i = 0; i < NCH; i++) flt_cnt[i] <= FLT_RELOAD;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rst_s2[i] != rst_prev[i]) begin
          flt_cnt[i]  <= FLT_RELOAD;
          rst_prev[i] <= rst_s2[i];
        end else if (flt_cnt[i] != 8'd0) begin
          flt_cnt[i] <= flt_cnt[i] - 8'd1;
          if (flt_cnt[i] == 8'd1) rst_filt_b[i] <= rst_s2[i];
        end
      end
    end
  end

  assign wr_flag  = bus.reg_wr && (bus.reg_addr == 4'd0);
  assign wr_mask  = bus.reg_wr && (bus.reg_addr == 4'd1);
  assign autoclr  = svmod_d & ~svmod_s;
  assign flag_set = ~rst_filt_b & {NCH{svmod_s}} & ~mask;
  assign flag_clr = (wr_flag ? bus.reg_wdata[NCH-1:0] : '0) |
                    (autoclr ? AUTOCLR_MASK : '0);
  // Set is ORed in after the clear so a simultaneous set wins.
  assign flag_nxt = flag_set | (flag & ~flag_clr);

  always_ff @(posedge CLK60MHZ or posedge pocrflclr) begin
    if (pocrflclr) begin
      flag     <= '0;
      mask     <= '0;
      flag_any <= 1'b0;
    end else begin
      flag     <= flag_nxt;
      flag_any <= |flag;
      if (wr_mask) mask <= bus.reg_wdata[NCH-1:0];
    end
  end

`ifdef RESET_DETECT_MC_CNT_EN
  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0]   rst_filt_d;
  logic [NCH-1:0]   filt_fall;

  // rst_filt_d resets inactive so the reset itself never counts as an edge.
  assign filt_fall = rst_filt_d & ~rst_filt_b & ~mask;

  always_ff @(posedge CLK60MHZ or posedge pocrflclr) begin
    if (pocrflclr) begin
      rst_filt_d <= '1;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      rst_filt_d <= rst_filt_b;
      for (int i = 0; i < NCH; i++) begin
        if (bus.reg_wr && (bus.reg_addr == 4'(8 + i)))
          cnt[i] <= bus.reg_wdata[CNT_W-1:0];
        else if (filt_fall[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (bus.reg_addr)
      4'd0:    rdata = 32'(flag);
      4'd1:    rdata = 32'(mask);
      4'd2:    rdata = 32'({svmod_s, rst_filt_b});
      default: rdata = '0;
    endcase
`ifdef RESET_DETECT_MC_CNT_EN
    for (int i = 0; i < NCH; i++)
      if (bus.reg_addr == 4'(8 + i)) rdata = 32'(cnt[i]);
`endif
  end

  assign bus.reg_rdata = rdata;

endmodule

// File: tb/tb_reset_detect_mc.sv
// Self-checking bench for reset_detect_mc: register-map vector table,
// hand-written filter/flag/counter/reset sequences and a randomized phase,
// all compared against a behavioural model every cycle.
module tb_reset_detect_mc;
  localparam int NCH = 4;
  localparam int FLT_LEN = 6;
  localparam int CNT_W = 2;
  localparam logic [NCH-1:0] AUTO = 4'b1000;
`ifdef RESET_DETECT_MC_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // clock / reset
  logic           clk;
  logic           pocrflclr;
  logic [NCH-1:0] rst_b;
  logic           svmoduser;
  logic [NCH-1:0] rst_filt_b;
  logic           flag_any;

  reset_detect_mc_if bus ();

  reset_detect_mc #(
    .NCH(NCH), .FLT_LEN(FLT_LEN), .CNT_W(CNT_W), .AUTOCLR_MASK(AUTO)
  ) dut (
    .CLK60MHZ(clk), .pocrflclr(pocrflclr), .rst_b(rst_b),
    .svmoduser(svmoduser), .bus(bus), .rst_filt_b(rst_filt_b),
    .flag_any(flag_any)
  );

  initial clk = 1'b0;
  always #8 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model: filter = last FLT_LEN synchronised samples agree
  logic [FLT_LEN+1:0] hist [NCH];   // hist[i][j] = raw sample j edges ago
  logic [3:0]         svh;          // svmoduser samples, [0] newest
  logic [NCH-1:0]     m_filt, m_filt_d, m_flag, m_mask;
  logic               m_flag_any;
  logic [CNT_W-1:0]   m_cnt [NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      hist[i]  = '1;
      m_cnt[i] = '0;
    end
    svh = '0;
    m_filt = '1; m_filt_d = '1; m_flag = '0; m_mask = '0; m_flag_any = 1'b0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] filt_pre, set_v, clr_v, fall_v, nf;
    logic [FLT_LEN-1:0] win;
    logic svs_pre, svd_pre;
    filt_pre = m_filt;
    svs_pre  = svh[1];
    svd_pre  = svh[2];
    set_v = ~filt_pre & {NCH{svs_pre}} & ~m_mask;
    clr_v = '0;
    if (bus.reg_wr && bus.reg_addr == 4'd0) clr_v = bus.reg_wdata[NCH-1:0];
    if (svd_pre && !svs_pre) clr_v = clr_v | AUTO;
    fall_v = m_filt_d & ~filt_pre & ~m_mask;
    for (int i = 0; i < NCH; i++) begin
      if (bus.reg_wr && bus.reg_addr == 4'(8 + i))
        m_cnt[i] = bus.reg_wdata[CNT_W-1:0];
      else if (fall_v[i] && int'(m_cnt[i]) < (1 << CNT_W) - 1)
        m_cnt[i] = CNT_W'(int'(m_cnt[i]) + 1);
    end
    m_flag_any = |m_flag;
    m_flag = set_v | (m_flag & ~clr_v);
    if (bus.reg_wr && bus.reg_addr == 4'd1) m_mask = bus.reg_wdata[NCH-1:0];
    svh = {svh[2:0], svmoduser};
    nf = filt_pre;
    for (int i = 0; i < NCH; i++) begin
      hist[i] = {hist[i][FLT_LEN:0], rst_b[i]};
      win = hist[i][FLT_LEN+1:2];
      if (win == '1) nf[i] = 1'b1;
      else if (win == '0) nf[i] = 1'b0;
    end
    m_filt_d = filt_pre;
    m_filt = nf;
  endtask

  function automatic logic [31:0] exp_rdata(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 4'd0) r = 32'(m_flag);
    else if (a == 4'd1) r = 32'(m_mask);
    else if (a == 4'd2) r = 32'({svh[1], m_filt});
    else if (CNT_ON && a >= 4'd8 && int'(a) - 8 < NCH) r = 32'(m_cnt[int'(a) - 8]);
    return r;
  endfunction

  // driver tasks: inputs change just after the falling edge
  task automatic step();
    @(posedge clk);
    if (!pocrflclr) model_edge();
    @(negedge clk);
    check("rst_filt_b", 32'(rst_filt_b), 32'(m_filt));
    check("flag_any", 32'(flag_any), 32'(m_flag_any));
    check("reg_rdata", bus.reg_rdata, exp_rdata(bus.reg_addr));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    step();
    bus.reg_wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    bus.reg_addr = a;
    #1;
    check(name, bus.reg_rdata, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [15];

  initial begin
    vecs[0]  = '{1'b0, 4'd0,  32'h0,        4'd0,  32'h0};
    vecs[1]  = '{1'b0, 4'd0,  32'h0,        4'd1,  32'h0};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,        4'd2,  32'hF};
    vecs[3]  = '{1'b0, 4'd0,  32'h0,        4'd8,  32'h0};
    vecs[4]  = '{1'b1, 4'd1,  32'hFFFFFFFA, 4'd1,  32'hA};
    vecs[5]  = '{1'b1, 4'd1,  32'h5,        4'd1,  32'h5};
    vecs[6]  = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'd3,  32'h0};
    vecs[7]  = '{1'b1, 4'd12, 32'hFF,       4'd12, 32'h0};
    vecs[8]  = '{1'b1, 4'd2,  32'h0,        4'd2,  32'hF};
    vecs[9]  = '{1'b1, 4'd9,  32'h3,        4'd9,  CNT_ON ? 32'h3 : 32'h0};
    vecs[10] = '{1'b1, 4'd9,  32'h5,        4'd9,  CNT_ON ? 32'h1 : 32'h0};
    vecs[11] = '{1'b1, 4'd0,  32'hF,        4'd0,  32'h0};
    vecs[12] = '{1'b1, 4'd1,  32'h0,        4'd1,  32'h0};
    vecs[13] = '{1'b1, 4'd9,  32'h0,        4'd9,  32'h0};
    vecs[14] = '{1'b0, 4'd0,  32'h0,        4'd1,  32'h0};

    pocrflclr = 1'b1; rst_b = '1; svmoduser = 1'b0;
    bus.reg_wr = 1'b0; bus.reg_addr = 4'd0; bus.reg_wdata = '0;
    model_reset();
    steps(3);
    check("reset_filt", 32'(rst_filt_b), 32'hF);
    check("reset_flag_any", 32'(flag_any), 32'h0);
    pocrflclr = 1'b0;
    steps(10);

    // register map table
    for (int i = 0; i < 15; i++) begin
      bus.reg_wr = vecs[i].wr; bus.reg_addr = vecs[i].waddr; bus.reg_wdata = vecs[i].wdata;
      step();
      bus.reg_wr = 1'b0;
      rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // short glitch is rejected, long pulse passes after 2+FLT_LEN cycles
    rst_b[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("glitch_hold", 32'(rst_filt_b[0]), 32'h1);
    end
    rst_b[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("glitch_after", 32'(rst_filt_b[0]), 32'h1);
    end
    rst_b[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 7) check("filt_lat7", 32'(rst_filt_b[0]), 32'h1);
      if (k == 8) check("filt_lat8", 32'(rst_filt_b[0]), 32'h0);
    end
    rst_b[0] = 1'b1;
    steps(12);

    // flag in break mode, write-1-clear
    svmoduser = 1'b1;
    steps(4);
    rst_b[1] = 1'b0; steps(20); rst_b[1] = 1'b1; steps(12);
    rd_chk("flag_ch1", 4'd0, 32'h2);
    check("flag_any_set", 32'(flag_any), 32'h1);
    wr_reg(4'd0, 32'h2);
    rd_chk("flag_w1c", 4'd0, 32'h0);
    step();
    check("flag_any_clr", 32'(flag_any), 32'h0);

    // set wins over a same-cycle clear
    rst_b[0] = 1'b0;
    steps(8);
    rd_chk("flag0_pre", 4'd0, 32'h0);
    wr_reg(4'd0, 32'h1);
    rd_chk("set_wins", 4'd0, 32'h1);
    rst_b[0] = 1'b1; steps(12);
    wr_reg(4'd0, 32'h1);
    rd_chk("flag0_clr", 4'd0, 32'h0);

    // masked channel: no flag, no count; autoclear on SVMOD exit
    wr_reg(4'd1, 32'h4);
    rst_b[2] = 1'b0; steps(20); rst_b[2] = 1'b1; steps(12);
    rd_chk("mask_noflag", 4'd0, 32'h0);
    rd_chk("mask_nocnt", 4'd10, 32'h0);
    wr_reg(4'd1, 32'h0);
    rst_b[3] = 1'b0; steps(20); rst_b[3] = 1'b1; steps(12);
    rd_chk("flag_ch3", 4'd0, 32'h8);
    svmoduser = 1'b0;
    steps(4);
    rd_chk("autoclr", 4'd0, 32'h0);

    // saturating counter with write-load
    wr_reg(4'd8, 32'h0);
    for (int p = 0; p < 4; p++) begin
      rst_b[0] = 1'b0; steps(10); rst_b[0] = 1'b1; steps(10);
    end
    rd_chk("cnt_sat", 4'd8, CNT_ON ? 32'h3 : 32'h0);
    wr_reg(4'd8, 32'h1);
    rd_chk("cnt_load", 4'd8, CNT_ON ? 32'h1 : 32'h0);

    // asynchronous reset with all flags set and counts nonzero
    svmoduser = 1'b1; steps(4);
    rst_b = '0; steps(12); rst_b = '1; steps(12);
    rd_chk("flags_all", 4'd0, 32'hF);
    wr_reg(4'd1, 32'h3);
    rd_chk("cnt_before_rst", 4'd8, CNT_ON ? 32'h2 : 32'h0);
    pocrflclr = 1'b1;
    model_reset();
    rd_chk("rst_flags", 4'd0, 32'h0);
    rd_chk("rst_mask", 4'd1, 32'h0);
    rd_chk("rst_cnt0", 4'd8, 32'h0);
    check("rst_flag_any", 32'(flag_any), 32'h0);
    check("rst_filt_async", 32'(rst_filt_b), 32'hF);
    steps(3);
    pocrflclr = 1'b0;
    steps(15);
    rd_chk("no_flag_from_reset", 4'd0, 32'h0);
    svmoduser = 1'b0;
    steps(4);

    // randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 9) == 0) rst_b[i] = ~rst_b[i];
      if ($urandom_range(0, 39) == 0) svmoduser = ~svmoduser;
      bus.reg_wr = ($urandom_range(0, 5) == 0);
      bus.reg_addr = 4'($urandom_range(0, 15));
      bus.reg_wdata = $urandom;
      if (!pocrflclr && $urandom_range(0, 599) == 0) begin
        pocrflclr = 1'b1;
        model_reset();
      end else if (pocrflclr && $urandom_range(0, 2) == 0) begin
        pocrflclr = 1'b0;
      end
      step();
    end
    bus.reg_wr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_detect_mc.md
RESET_DETECT_MC -- requirements
Module: reset_detect_mc

Interface
REQ-001 Parameter NCH, default 4, number of reset-source channels (legal 1..8).
REQ-002 Parameter FLT_LEN, default 6, stable CLK60MHZ cycles needed to accept a level change (legal 2..255).
REQ-003 Parameter CNT_W, default 8, width of each per-channel event counter (legal 1..24).
REQ-004 Parameter AUTOCLR_MASK, default {NCH{1'b0}}, channels whose flag clears on the falling edge of user-SVMOD.
REQ-005 CLK60MHZ  input  1  system clock; all state is on its rising edge.
REQ-006 pocrflclr  input  1  reset, asynchronous, active-high.
REQ-007 rst_b  input  NCH  raw active-low reset sources, asynchronous to CLK60MHZ.
REQ-008 svmoduser  input  1  break-mode user SVMOD, asynchronous.
REQ-009 reg_wr  input  1  host write strobe, one cycle, synchronous.
REQ-010 reg_addr  input  4  host register address.
REQ-011 reg_wdata  input  32  host write data.
REQ-012 reg_rdata  output  32  host read data, combinational from reg_addr and registers.
REQ-013 rst_filt_b  output  NCH  noise-filtered active-low resets.
REQ-014 flag_any  output  1  OR of all flag bits (break-fail request).

Function
REQ-015 Each rst_b bit and svmoduser SHALL pass through a 2-flop synchroniser before any use.
REQ-016 Per channel, a down-counter SHALL reload to FLT_LEN-1 whenever the synchronised input differs from the previous sample, and rst_filt_b SHALL take the synchronised value once the counter reaches 0 with the input unchanged.
REQ-017 Glitches shorter than FLT_LEN cycles SHALL NOT change rst_filt_b. Filter latency from a stable raw edge to rst_filt_b = 2 + FLT_LEN cycles.
REQ-018 flag[i] SHALL set when rst_filt_b[i]=0, svmod_s=1 and mask[i]=0. Once set, flag[i] SHALL hold until it is cleared.
REQ-019 flag[i] SHALL clear in three cases: a write of 1 to bit i at address 0; a svmod_s 1->0 edge with AUTOCLR_MASK[i]=1; or pocrflclr.
REQ-020 If set and clear occur in the same cycle, set SHALL win.
REQ-021 Event counter cnt[i] SHALL increment on each filtered 1->0 edge of rst_filt_b[i] while mask[i]=0. It SHALL saturate at all-ones and SHALL NOT wrap.
REQ-022 A write to address 8+i, i<NCH, SHALL load cnt[i] from reg_wdata[CNT_W-1:0]. If an increment coincides with the write, the write SHALL win.
REQ-023 Register map: 0 = flags (R, write-1-clear); 1 = mask[NCH-1:0] (R/W); 2 = {svmod_s, rst_filt_b} (RO); 8..8+NCH-1 = cnt[i] (R/W).
REQ-024 Unused reg_rdata bits SHALL read 0. Reserved addresses SHALL read 0 and ignore writes.
REQ-025 flag_any SHALL be the registered OR of flag, one cycle after the flag change.

Reset
REQ-026 While pocrflclr=1, the following SHALL hold:
- all flags 0, mask 0, counters 0, flag_any 0;
- synchronisers and rst_filt_b at 1 (inactive);
- filter counters at FLT_LEN-1.
REQ-027 Deassertion of pocrflclr mid-operation SHALL restart filtering from the inactive state. No flag or count SHALL result from the reset itself.

Configuration
REQ-028 Macro RESET_DETECT_MC_CNT_EN defined: event counters are present per REQ-021/022.
REQ-029 Macro RESET_DETECT_MC_CNT_EN undefined: no counter flops are built, addresses 8..15 read 0, and writes to them are ignored. All other behaviour is identical.

Verification
REQ-030 Filter: rst_b[0]=0 pulse of 5 cycles with FLT_LEN=6 -> rst_filt_b[0] stays 1. A 20-cycle pulse -> rst_filt_b[0]=0 exactly 8 cycles after the raw edge.
REQ-031 Flag: svmoduser=1, mask=0, rst_b[1] low 20 cycles -> flag=4'b0010, flag_any=1. Write 0x2 to address 0 -> flag=0.
REQ-032 Set-wins: write 0x1 to address 0 in the same cycle flag[0] is set -> flag[0] remains 1.
REQ-033 Mask/autoclear: mask=0x4, rst_b[2] pulsed -> no flag and no count. With AUTOCLR_MASK=4'b1000, flag[3] set then svmoduser 1->0 -> flag[3]=0 within 4 cycles.
REQ-034 Counter (CNT_EN): CNT_W=2, four filtered edges on channel 0 -> address 8 reads 3. Write 1 to address 8 -> reads 1. Without the macro, address 8 reads 0.
REQ-035 Reset: pocrflclr pulsed while flags=0xF and counts are nonzero -> all registers read 0 immediately, with no clock edge needed.
